// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: pipelined imem fetch front end with an in-order
// DEPTH-entry queue. `define PREFETCH_PERF_EN adds the starve_cnt_o port.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] starve_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:2]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];

  logic [CW:0]   w_credit;
  logic [CW-1:0] w_outst_rsp;
  logic          w_valid;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_drop_rsp;

  // Credits cover queued entries plus requests still in flight,
  // so a returning response always finds a free slot.
  assign w_credit = {1'b0, r_count} + {1'b0, r_outst};

  assign imem_req_valid = rst_n && !redirect_i &&
                          (w_credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = {r_fetch_pc, 2'b00};

  assign w_accept    = imem_req_valid && imem_req_ready;
  assign w_outst_rsp = r_outst - CW'(imem_rsp_valid);
  assign w_drop_rsp  = imem_rsp_valid && (r_drop != '0);
  assign w_push      = imem_rsp_valid && (r_drop == '0) && !redirect_i;
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && !stall_i && !redirect_i;

  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_q_instr[r_rd_ptr] : NOP;
  assign pc_o          = w_valid ? r_q_pc[r_rd_ptr] : r_rsp_pc;
  assign pc_plus4_o    = pc_o + 32'd4;

  // Fetch/response PCs, queue pointers and in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC[31:2];
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i[31:2];
      r_rsp_pc   <= redirect_pc_i;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_outst    <= w_outst_rsp;
      r_drop     <= w_outst_rsp;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 30'd1;
      end
      r_outst <= w_outst_rsp + CW'(w_accept);
      if (w_drop_rsp) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue storage; only written on push, contents gated by r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rsp_data;
      r_q_pc[r_wr_ptr]    <= r_rsp_pc;
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [31:0] r_starve_cnt;

  // Saturating count of cycles decode wanted an instruction but had none
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!w_valid && !stall_i &&
                 (r_starve_cnt != 32'hFFFF_FFFF)) begin
      r_starve_cnt <= r_starve_cnt + 32'd1;
    end
  end

  assign starve_cnt_o = r_starve_cnt;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed bench with an in-order imem model
// of configurable latency and request-ready pattern.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
`ifdef PREFETCH_PERF_EN
  logic [31:0] starve_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  int lat_fixed = 1;
  bit lat_rand  = 1'b0;
  bit tog       = 1'b0;
  int cyc       = 0;

  logic [31:0] pend_a [$];
  int          pend_d [$];

  instr_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .instr_valid_o  (instr_valid_o)
`ifdef PREFETCH_PERF_EN
    ,
    .starve_cnt_o   (starve_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC3A5_0000;
  endfunction

  // In-order imem: each accepted request answers lat cycles later
  always @(posedge clk) begin
    if (!rst_n) begin
      pend_a.delete();
      pend_d.delete();
      imem_rsp_valid <= 1'b0;
    end else begin
      if (imem_rsp_valid) begin
        void'(pend_a.pop_front());
        void'(pend_d.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_a.push_back(imem_req_addr);
        pend_d.push_back(cyc + (lat_rand ?
          int'($urandom_range(1, 3)) : lat_fixed));
      end
      if (pend_a.size() > 0 && pend_d[0] <= cyc + 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= memf(pend_a[0]);
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next valid head and check it against the model
  task automatic expect_next(input string tag, input logic [31:0] epc);
    bit seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      redirect_i = 1'b0;
      if (tog) imem_req_ready = ~imem_req_ready;
      #1;
      if (instr_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_pc"}, pc_o, epc);
    chk({tag, "_instr"}, instr_o, memf(epc));
    chk({tag, "_pc4"}, pc_plus4_o, epc + 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    rst_n          = 1'b0;
    stall_i        = 1'b0;
    redirect_i     = 1'b0;
    redirect_pc_i  = 32'h0;
    imem_req_ready = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
`ifdef PREFETCH_PERF_EN
    chk("rst_starve", starve_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_addr0", imem_req_addr, 32'h0);
    @(negedge clk); #1;
    chk("t1_addr4", imem_req_addr, 32'h4);
    chk("t1_notvalid", 32'(instr_valid_o), 32'd0);
    @(negedge clk); #1;
    chk("t1_valid", 32'(instr_valid_o), 32'd1);
    chk("t1_pc0", pc_o, 32'h0);
    chk("t1_instr0", instr_o, memf(32'h0));
    chk("t1_pc4_0", pc_plus4_o, 32'h4);
    @(negedge clk); #1;
    chk("t1_pc4", pc_o, 32'h4);
    @(negedge clk);
    stall_i = 1'b1;
    #1;
    chk("t1_pc8", pc_o, 32'h8);

    // Stall: outputs frozen, issue stops at 4 credits
    repeat (3) @(negedge clk);
    #1;
    chk("t2_pc_hold", pc_o, 32'h8);
    chk("t2_instr_hold", instr_o, memf(32'h8));
    chk("t2_req_stop", 32'(imem_req_valid), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("t2_pc_hold2", pc_o, 32'h8);
    chk("t2_req_stop2", 32'(imem_req_valid), 32'd0);
    stall_i = 1'b0;
    e = 32'hC;
    for (int i = 0; i < 4; i++) begin
      expect_next("t2_seq", e);
      e += 32'd4;
    end

    // Redirect with stall, 1-cycle imem: valid again 2 cycles later
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    stall_i       = 1'b1;
    #1;
    chk("rd_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    #1;
    chk("rd_flush", 32'(instr_valid_o), 32'd0);
    chk("rd_addr", imem_req_addr, 32'h200);
    chk("rd_req", 32'(imem_req_valid), 32'd1);
    @(negedge clk); #1;
    chk("rd_gap", 32'(instr_valid_o), 32'd0);
    @(negedge clk); #1;
    chk("rd_valid", 32'(instr_valid_o), 32'd1);
    chk("rd_pc", pc_o, 32'h200);
    chk("rd_instr", instr_o, memf(32'h200));

    // 2-cycle imem builds 2 in flight, then redirect drops stale data
    lat_fixed = 2;
    e = 32'h204;
    for (int i = 0; i < 6; i++) begin
      expect_next("t3_lat2", e);
      e += 32'd4;
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    expect_next("t3_tgt", 32'h100);
    expect_next("t3_tgt", 32'h104);
    expect_next("t3_tgt", 32'h108);

    // Ready toggling and random 1..3 cycle latency
    lat_rand = 1'b1;
    tog      = 1'b1;
    e = 32'h10C;
    for (int i = 0; i < 16; i++) begin
      expect_next("t4_seq", e);
      e += 32'd4;
    end
    e -= 32'd4;

    // Fill the queue, then reset mid-stream
    tog            = 1'b0;
    lat_rand       = 1'b0;
    lat_fixed      = 1;
    imem_req_ready = 1'b1;
    stall_i        = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("t5_full_req", 32'(imem_req_valid), 32'd0);
    chk("t5_full_pc", pc_o, e);
    rst_n   = 1'b0;
    stall_i = 1'b0;
    @(negedge clk); #1;
    chk("t5_valid", 32'(instr_valid_o), 32'd0);
    chk("t5_req", 32'(imem_req_valid), 32'd0);
    chk("t5_pc", pc_o, 32'h0);
    chk("t5_instr", instr_o, 32'h0000_0013);
`ifdef PREFETCH_PERF_EN
    chk("t5_starve0", starve_cnt_o, 32'd0);
`endif
    rst_n          = 1'b1;
    imem_req_ready = 1'b0;
    #1;
    chk("t5_addr0", imem_req_addr, 32'h0);
    @(negedge clk);
    imem_req_ready = 1'b1;
    #1;
    chk("t5_wait_addr", imem_req_addr, 32'h0);
    chk("t5_wait1", 32'(instr_valid_o), 32'd0);
    @(negedge clk); #1;
    chk("t5_wait2", 32'(instr_valid_o), 32'd0);
    @(negedge clk); #1;
    chk("t5_rvalid", 32'(instr_valid_o), 32'd1);
    chk("t5_rpc", pc_o, 32'h0);
    chk("t5_rinstr", instr_o, memf(32'h0));
`ifdef PREFETCH_PERF_EN
    chk("t5_starve3", starve_cnt_o, 32'd3);
`endif
    @(negedge clk); #1;
    chk("t5_rpc4", pc_o, 32'h4);
`ifdef PREFETCH_PERF_EN
    chk("t5_starve_hold", starve_cnt_o, 32'd3);
`endif

    // Fetch PC wrap at 2^32
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    chk("t6_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("t6_addr_wrap", imem_req_addr, 32'h0);
    @(negedge clk); #1;
    chk("t6_valid", 32'(instr_valid_o), 32'd1);
    chk("t6_pc", pc_o, 32'hFFFF_FFFC);
    chk("t6_pc4", pc_plus4_o, 32'h0);
    chk("t6_instr", instr_o, memf(32'hFFFF_FFFC));
    @(negedge clk); #1;
    chk("t6_pc_wrap", pc_o, 32'h0);
    chk("t6_instr_wrap", instr_o, memf(32'h0));

    // Misaligned redirect target
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h302;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    chk("mis_addr", imem_req_addr, 32'h300);
    repeat (2) @(negedge clk);
    #1;
    chk("mis_pc", pc_o, 32'h302);
    chk("mis_pc4", pc_plus4_o, 32'h306);
    chk("mis_instr", instr_o, memf(32'h300));
    @(negedge clk); #1;
    chk("mis_pc_next", pc_o, 32'h306);
    chk("mis_instr_next", instr_o, memf(32'h304));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
